seq_divider_8bit: RTL and testbench
===================================

Name: seq_divider_8bit

Overview:
- Sequential unsigned restoring divider, WIDTH/WIDTH -> WIDTH quotient + WIDTH remainder.
- One quotient bit per clock, Run/Done handshake.
- Inverse companion to the lab5 shift-add multiplier datapath; shares its Run/Done control style.
- Sits beside the multiplier under the same top level, driven from switches/Run button, results to hex displays.

Parameters:
WIDTH, 8, operand/quotient/remainder width; counter width = clog2(WIDTH+1).

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
Run  input  1  level start request; sampled only in IDLE
Dividend  input  WIDTH  unsigned dividend, captured on start edge only
Divisor  input  WIDTH  unsigned divisor, captured on start edge only
Quotient  output  WIDTH  registered result; holds last value until next completion
Remainder  output  WIDTH  registered result; holds last value until next completion
Busy  output  1  high in ITER
Done  output  1  high in DONE
DivZero  output  1  registered; set at completion of a divide-by-zero op, cleared at next start

Behaviour:
- Reset (async, any state): state=IDLE; Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0; internal R, Q, M, count = 0. Reset mid-ITER aborts; no partial result reaches outputs.
- Internal regs: R (WIDTH+1 bits, partial remainder), Q (WIDTH), M (WIDTH), count.
- States: IDLE, ITER, DONE.
- IDLE: Run=1 at edge ->
  - Divisor!=0: R=0, Q=Dividend, M=Divisor, count=0, DivZero=0, go to ITER.
  - Divisor==0: Quotient={WIDTH{1}}, Remainder=Dividend, DivZero=1, go to DONE. Latency 1 edge.
  - Run=0: stay.
- ITER, per edge:
  - Rs = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits); Qs = {Q[WIDTH-2:0], 0}.
  - T = Rs - {0,M}, computed WIDTH+2 bits wide, so borrow = T[WIDTH+1].
  - No borrow: R=T[WIDTH:0], Q=Qs|1. Borrow: R=Rs, Q=Qs (restore).
  - count++. On the edge where count goes to WIDTH: Quotient=new Q, Remainder=new R[WIDTH-1:0], go to DONE.
  - Done first high exactly WIDTH+1 edges after the start edge (9 for WIDTH=8).
  - Run ignored during ITER; Dividend/Divisor changes ignored after capture.
- DONE:
  - Done=1, Busy=0, outputs stable.
  - Run=1: stay (no auto-restart while held).
  - Run=0: go to IDLE next edge; Done clears; Quotient/Remainder/DivZero hold.
- Invariants at completion: Dividend = Quotient*Divisor + Remainder; Remainder < Divisor. R[WIDTH] is always 0 at completion.
- Boundaries:
  - Dividend < Divisor -> Q=0, R=Dividend.
  - Dividend == Divisor -> Q=1, R=0.
  - Divisor=1 -> Q=Dividend, R=0.
  - Dividend=0 -> Q=0, R=0 (full WIDTH iterations still run).
- Busy and Done are never high together. Outputs are glitch-free (registers only), no combinational input-to-output path.

Test Plan:
- Reset, Dividend=100, Divisor=7, pulse Run high 1 cycle -> Busy high 8 cycles; Done on 9th edge; Quotient=14, Remainder=2, DivZero=0.
- 255/1 -> Quotient=255, Remainder=0. Then 5/9 -> Quotient=0, Remainder=5. Then 0xFF/0xFF -> Quotient=1, Remainder=0.
- 200/0 -> Done 1 edge after start; Quotient=0xFF, Remainder=0xC8, DivZero=1, Busy never high. Next op 10/3 clears DivZero -> Quotient=3, Remainder=1.
- Start 100/7, assert Reset mid-cycle after 4th ITER edge -> outputs immediately 0, state IDLE, Done=0. Release Reset, run 100/7 again -> Quotient=14, Remainder=2.
- Hold Run high through completion of 255/16 -> Done stays, no restart, Quotient=15, Remainder=15 stable for 20 cycles. Change Dividend/Divisor mid-ITER of next op (64/8 -> 3/3) -> result 8/0 unaffected.
- Random sweep, 2000 operand pairs incl. 0 and 255 -> invariant Dividend == Quotient*Divisor + Remainder, Remainder < Divisor, fixed latency 9 (1 if Divisor=0).

Source files
------------

// File: rtl/seq_divider_8bit.sv
// ---------------------------------------------------------------------------
// seq_divider_8bit
//   Sequential unsigned restoring divider. It produces one quotient bit per
//   clock and uses a Run/Done handshake. It matches the control style of the
//   shift-add multiplier that sits beside it.
//
// Ports
//   i_clk        system clock; all state changes on the rising edge
//   i_rst        asynchronous active-high reset; clears all state
//   i_run        level start request; sampled only while idle
//   i_dividend   unsigned dividend; captured on the start edge only
//   i_divisor    unsigned divisor; captured on the start edge only
//   o_quotient   registered quotient; holds until the next completion
//   o_remainder  registered remainder; holds until the next completion
//   o_busy       high while iterating
//   o_done       high while a result is presented (until Run is released)
//   o_div_zero   set on completion of a divide-by-zero, cleared at next start
// ---------------------------------------------------------------------------
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Partial remainder. Between iterations it is always below the divisor,
  // so its top bit is zero and is not stored. Only the shifted value below
  // is formed WIDTH+1 bits wide.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH-1:0] w_qs;
  logic             w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_start;
  logic             w_zero_div;

  // One restoring step: shift the next dividend bit into the remainder,
  // then try to subtract the divisor.
  assign w_rs     = {r_rem, r_q[WIDTH-1]};
  assign w_qs     = {r_q[WIDTH-2:0], 1'b0};
  assign w_borrow = (w_rs < {1'b0, r_m});
  // On a successful subtract the difference is below the divisor, so the
  // low WIDTH bits hold it exactly.
  assign w_diff     = w_rs[WIDTH-1:0] - r_m;
  assign w_rem_next = w_borrow ? w_rs[WIDTH-1:0] : w_diff;
  assign w_q_next   = w_borrow ? w_qs : (w_qs | {{(WIDTH-1){1'b0}}, 1'b1});

  assign w_last     = (r_count == CW'(WIDTH - 1));
  assign w_start    = (r_state == S_IDLE) && i_run;
  assign w_zero_div = (i_divisor == '0);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_next = w_zero_div ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Hold the result while Run is still asserted, so a held button
        // does not immediately restart.
        if (!i_run) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      // Flags come from the next state, so each is a plain flop.
      r_busy <= (w_state_next == S_ITER);
      r_done <= (w_state_next == S_DONE);

      if (w_start) begin
        if (w_zero_div) begin
          // Divide by zero completes at once with an all-ones quotient.
          r_quotient  <= '1;
          r_remainder <= i_dividend;
          r_div_zero  <= 1'b1;
        end else begin
          r_rem      <= '0;
          r_q        <= i_dividend;
          r_m        <= i_divisor;
          r_count    <= '0;
          r_div_zero <= 1'b0;
        end
      end else if (r_state == S_ITER) begin
        r_rem   <= w_rem_next;
        r_q     <= w_q_next;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_quotient  <= w_q_next;
          r_remainder <= w_rem_next;
        end
      end
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_8bit
//   Self-checking bench for seq_divider_8bit.
//   Expected results are pushed to a scoreboard when an operation is
//   launched. They are popped and compared when Done rises.
// ---------------------------------------------------------------------------
module tb_seq_divider_8bit;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];

  seq_divider_8bit #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_run       (run),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_busy      (busy),
    .o_done      (done),
    .o_div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait for Done, and compare against the scoreboard.
  // hold:       keep Run high after the start edge
  // change_mid: change the operand inputs in the middle of the iterations
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input bit hold, input bit change_mid);
    exp_t e;
    exp_t got_e;
    int   lat;
    int   busy_cnt;
    bit   got;
    e.q           = (b == 8'd0) ? 8'hFF : 8'(a / b);
    e.r           = (b == 8'd0) ? a     : 8'(a % b);
    e.dz          = (b == 8'd0);
    e.lat         = (b == 8'd0) ? 1 : 9;
    e.busy_cycles = (b == 8'd0) ? 0 : 8;
    sb.push_back(e);

    @(negedge clk);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold) run = 1'b0;
      if (change_mid && lat == 3) begin
        dividend = 8'd3;
        divisor  = 8'd3;
      end
      if (busy && done) chk("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    chk("done_timeout", 32'(got), 32'd1);
    got_e = sb.pop_front();
    chk("quotient",    32'(quotient),  32'(got_e.q));
    chk("remainder",   32'(remainder), 32'(got_e.r));
    chk("div_zero",    32'(div_zero),  32'(got_e.dz));
    chk("latency",     32'(lat),       32'(got_e.lat));
    chk("busy_cycles", 32'(busy_cnt),  32'(got_e.busy_cycles));
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0b lat=%0d", a, b, quotient, remainder, div_zero, lat);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("done_clears", 32'(done), 32'd0);
      chk("q_holds",     32'(quotient), 32'(got_e.q));
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    rst      = 1'b1;
    run      = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #3;
    chk("rst_quotient",  32'(quotient),  32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_div_zero",  32'(div_zero),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations
    do_op(8'd100, 8'd7,   1'b0, 1'b0);
    do_op(8'd255, 8'd1,   1'b0, 1'b0);
    do_op(8'd5,   8'd9,   1'b0, 1'b0);
    do_op(8'hFF,  8'hFF,  1'b0, 1'b0);
    do_op(8'd200, 8'd0,   1'b0, 1'b0);
    do_op(8'd10,  8'd3,   1'b0, 1'b0);

    // Reset in the middle of an iteration aborts the operation
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    run      = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_quotient",  32'(quotient),  32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_done",      32'(done),      32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    $display("reset abort -> q=%0d r=%0d busy=%0b done=%0b", quotient, remainder, busy, done);
    do_op(8'd100, 8'd7, 1'b0, 1'b0);

    // Holding Run keeps the result presented without restarting
    do_op(8'd255, 8'd16, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("hold_done",      32'(done),      32'd1);
      chk("hold_busy",      32'(busy),      32'd0);
      chk("hold_quotient",  32'(quotient),  32'd15);
      chk("hold_remainder", 32'(remainder), 32'd15);
    end
    $display("hold 20 cycles -> q=%0d r=%0d done=%0b", quotient, remainder, done);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release_done", 32'(done), 32'd0);

    // Operand changes after capture do not affect the result
    do_op(8'd64, 8'd8, 1'b0, 1'b1);

    // Random sweep with forced corner operands
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i % 37 == 0) a = 8'd0;
      if (i % 41 == 0) a = 8'd255;
      if (i % 43 == 0) b = 8'd0;
      if (i % 47 == 0) b = 8'd255;
      if (i % 53 == 0) b = 8'd1;
      do_op(a, b, 1'b0, 1'b0);
      if (b != 8'd0) begin
        chk("invariant_sum", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("invariant_lt",  32'(remainder < b), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
